// File: rtl/data_skewer_pkg.sv
// Shared definitions for the 2d-stream skew generator.
// Status bit positions and counter sizing helper.
package data_skewer_pkg;

  localparam int STS_OVF   = 0;
  localparam int STS_EMPTY = 1;
  localparam int STS_FULL  = 2;
  localparam int STS_PEND  = 3;

  // One spare bit keeps release stamps unambiguous across wrap.
  function automatic int cnt_w(input int delay);
    return $clog2(delay + 1) + 1;
  endfunction

endpackage

// File: rtl/data_skewer_fifo.sv
// Single-clock circular FIFO with registered flags.
// Push while full is accepted only alongside a pop.
module skew_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i & ~empty_q;
    do_push = push_i & (~full_q | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = inc(wr_q);
    end
    if (do_pop) rd_d = inc(rd_q);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/data_skewer.sv
// Splits an aligned pair stream into two streams, the 2d one
// lagging by a fixed number of clocks via a timestamped FIFO.
module data_skewer
  import data_skewer_pkg::*;
#(
  parameter int                   DATA_W_1ST         = 32,
  parameter int                   DATA_W_2D          = 32,
  parameter logic [DATA_W_2D-1:0] DEFAULT_ELEMENT_2D = '0,
  parameter int                   DELAY_BW_1ST_2D    = 4,
  parameter int                   DEPTH_FIFO         = DELAY_BW_1ST_2D
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_W_1ST-1:0] data_1st_i,
  input  logic [DATA_W_2D-1:0]  data_2d_i,
  input  logic                  vld_i,
  output logic [DATA_W_1ST-1:0] data_1st_o,
  output logic                  vld_1st_o,
  output logic [DATA_W_2D-1:0]  data_2d_o,
  output logic                  vld_2d_o,
  output logic [3:0]            statuses_o
);

  localparam int CNT_W = cnt_w(DELAY_BW_1ST_2D);

  logic [DATA_W_1ST-1:0] data_1st_q, data_1st_d;
  logic                  vld_1st_q, vld_1st_d;
  logic [DATA_W_2D-1:0]  data_2d_q, data_2d_d;
  logic                  vld_2d_q, vld_2d_d;
  logic [3:0]            sts;

  always_comb begin
    vld_1st_d  = vld_i;
    data_1st_d = vld_i ? data_1st_i : data_1st_q;
  end

  generate
    if (DELAY_BW_1ST_2D == 0) begin : g_bypass
      always_comb begin
        vld_2d_d        = vld_i;
        data_2d_d       = vld_i ? data_2d_i : DEFAULT_ELEMENT_2D;
        sts             = '0;
        sts[STS_EMPTY]  = 1'b1;
      end
    end else begin : g_fifo
      typedef struct packed {
        logic [DATA_W_2D-1:0] data;
        logic [CNT_W-1:0]     rel;
      } entry_t;

      entry_t           push_e, head_e;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             pop, empty, full;

      // Head leaves exactly when the free-running count hits its stamp.
      always_comb begin
        cnt_d          = cnt_q + CNT_W'(1);
        push_e.data    = data_2d_i;
        push_e.rel     = cnt_q + CNT_W'(DELAY_BW_1ST_2D);
        pop            = ~empty & (head_e.rel == cnt_q);
        ovf_d          = ovf_q | (vld_i & full & ~pop);
        vld_2d_d       = pop;
        data_2d_d      = pop ? head_e.data : DEFAULT_ELEMENT_2D;
        sts            = '0;
        sts[STS_OVF]   = ovf_q;
        sts[STS_EMPTY] = empty;
        sts[STS_FULL]  = full;
        sts[STS_PEND]  = ~empty;
      end

      skew_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH_FIFO)
      ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push_i  (vld_i),
        .data_i  (push_e),
        .pop_i   (pop),
        .data_o  (head_e),
        .empty_o (empty),
        .full_o  (full)
      );

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      data_1st_q <= '0;
      vld_1st_q  <= 1'b0;
      data_2d_q  <= DEFAULT_ELEMENT_2D;
      vld_2d_q   <= 1'b0;
    end else begin
      data_1st_q <= data_1st_d;
      vld_1st_q  <= vld_1st_d;
      data_2d_q  <= data_2d_d;
      vld_2d_q   <= vld_2d_d;
    end
  end

  assign data_1st_o = data_1st_q;
  assign vld_1st_o  = vld_1st_q;
  assign data_2d_o  = data_2d_q;
  assign vld_2d_o   = vld_2d_q;
  assign statuses_o = sts;

endmodule

// File: tb/tb_data_skewer.sv
// Bench for data_skewer: delay 4 / depth 4, delay 4 / depth 2
// and delay 0 instances against a queue-based scoreboard.
module tb_data_skewer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        vld_i;
  logic [31:0] d1_i, d2_i;
  logic        o_vld_i;
  logic [31:0] o_d1_i, o_d2_i;

  logic [31:0] m_d1, m_d2, o_d1, o_d2, z_d1, z_d2;
  logic        m_v1, m_v2, o_v1, o_v2, z_v1, z_v2;
  logic [3:0]  m_sts, o_sts, z_sts;

  always #5 clk = ~clk;

  data_skewer #(
    .DELAY_BW_1ST_2D (D),
    .DEPTH_FIFO      (4)
  ) u_main (
    .clk (clk), .aresetn (aresetn),
    .data_1st_i (d1_i), .data_2d_i (d2_i), .vld_i (vld_i),
    .data_1st_o (m_d1), .vld_1st_o (m_v1),
    .data_2d_o (m_d2), .vld_2d_o (m_v2), .statuses_o (m_sts)
  );

  data_skewer #(
    .DELAY_BW_1ST_2D (D),
    .DEPTH_FIFO      (2)
  ) u_ovf (
    .clk (clk), .aresetn (aresetn),
    .data_1st_i (o_d1_i), .data_2d_i (o_d2_i), .vld_i (o_vld_i),
    .data_1st_o (o_d1), .vld_1st_o (o_v1),
    .data_2d_o (o_d2), .vld_2d_o (o_v2), .statuses_o (o_sts)
  );

  data_skewer #(
    .DELAY_BW_1ST_2D (0),
    .DEPTH_FIFO      (1)
  ) u_zero (
    .clk (clk), .aresetn (aresetn),
    .data_1st_i (d1_i), .data_2d_i (d2_i), .vld_i (vld_i),
    .data_1st_o (z_d1), .vld_1st_o (z_v1),
    .data_2d_o (z_d2), .vld_2d_o (z_v2), .statuses_o (z_sts)
  );

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sts;
  } vec_t;

  exp_t        q1[$];
  exp_t        q2[$];
  vec_t        vecs[20];
  int          n;
  logic [31:0] last1;
  int          checks = 0;
  int          errors = 0;

  localparam logic [11:0] SPARSE = 12'b0000_0101_1001;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %h want %h", nm, n, act, exp);
    end
  endtask

  task automatic check_main();
    bit          e1, e2;
    logic [31:0] eb1, eb2;
    e1  = (q1.size() > 0) && (q1[0].due == n);
    e2  = (q2.size() > 0) && (q2[0].due == n);
    eb1 = '0;
    eb2 = '0;
    if (e1) begin
      last1 = q1[0].a;
      eb1   = q1[0].b;
      void'(q1.pop_front());
    end
    if (e2) begin
      eb2 = q2[0].b;
      void'(q2.pop_front());
    end
    chk("m_vld_1st", 64'(m_v1), 64'(e1));
    chk("m_data_1st", 64'(m_d1), 64'(last1));
    chk("m_vld_2d", 64'(m_v2), 64'(e2));
    chk("m_data_2d", 64'(m_d2), 64'(eb2));
    chk("z_vld_1st", 64'(z_v1), 64'(e1));
    chk("z_vld_2d", 64'(z_v2), 64'(e1));
    chk("z_data_2d", 64'(z_d2), 64'(eb1));
    chk("z_sts", 64'(z_sts), 64'(4'b0010));
  endtask

  task automatic cycle(input bit v, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    n++;
    check_main();
    vld_i = v;
    d1_i  = a;
    d2_i  = b;
    if (v) begin
      q1.push_back('{due: n + 1, a: a, b: b});
      q2.push_back('{due: n + 1 + D, a: a, b: b});
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_vld_1st"}, 64'(m_v1), 64'(0));
    chk({tag, "_m_data_1st"}, 64'(m_d1), 64'(0));
    chk({tag, "_m_vld_2d"}, 64'(m_v2), 64'(0));
    chk({tag, "_m_data_2d"}, 64'(m_d2), 64'(0));
    chk({tag, "_m_sts"}, 64'(m_sts), 64'(4'b0010));
    chk({tag, "_o_sts"}, 64'(o_sts), 64'(4'b0010));
    chk({tag, "_z_sts"}, 64'(z_sts), 64'(4'b0010));
    chk({tag, "_z_vld_2d"}, 64'(z_v2), 64'(0));
  endtask

  initial begin
    vld_i   = 0;
    d1_i    = 0;
    d2_i    = 0;
    o_vld_i = 0;
    o_d1_i  = 0;
    o_d2_i  = 0;
    n       = 0;
    last1   = 0;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{v: (i == 0),
                  a: (i == 0) ? 32'hA1 : 32'h0,
                  b: (i == 0) ? 32'hB1 : 32'h0,
                  sts: (i >= 1 && i <= 4) ? 4'b1000 : 4'b0010};
    for (int i = 0; i < 12; i++)
      vecs[8 + i] = '{v: SPARSE[i],
                      a: 32'h10 + i,
                      b: 32'h20 + i,
                      sts: (i >= 1 && i <= 10) ? 4'b1000 : 4'b0010};

    repeat (3) @(negedge clk);
    check_reset("init");
    aresetn = 1'b1;

    // single pair, then sparse pattern
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].v, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_sts", i), 64'(m_sts), 64'(vecs[i].sts));
    end

    // continuous stream 1..20
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'(i + 1), 32'(i + 1));
      if (i >= 4) chk("cont_full", 64'(m_sts[2]), 64'(1));
      chk("cont_ovf", 64'(m_sts[0]), 64'(0));
    end
    repeat (8) cycle(1'b0, '0, '0);
    chk("cont_drained", 64'(m_sts), 64'(4'b0010));

    // overflow on the depth-2 instance
    for (int k = 0; k < 12; k++) begin
      logic        ev;
      logic [31:0] ed;
      cycle(1'b0, '0, '0);
      ev = (k == 5) || (k == 6);
      ed = (k == 5) ? 32'h1 : (k == 6) ? 32'h2 : 32'h0;
      chk($sformatf("ovf%0d_vld_2d", k), 64'(o_v2), 64'(ev));
      chk($sformatf("ovf%0d_data_2d", k), 64'(o_d2), 64'(ed));
      chk($sformatf("ovf%0d_flag", k), 64'(o_sts[0]), 64'(k >= 3));
      o_vld_i = (k < 4);
      o_d1_i  = 32'(k + 1);
      o_d2_i  = 32'(k + 1);
    end
    o_vld_i = 0;
    chk("ovf_sticky_sts", 64'(o_sts), 64'(4'b0011));

    // random traffic
    for (int i = 0; i < 50; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom);
    repeat (8) cycle(1'b0, '0, '0);
    chk("rand_q_empty", 64'(q2.size()), 64'(0));

    // reset with 2d elements in flight
    cycle(1'b1, 32'hC1, 32'hD1);
    cycle(1'b1, 32'hC2, 32'hD2);
    @(negedge clk);
    n++;
    check_main();
    vld_i = 0;
    chk("pre_rst_pend", 64'(m_sts[3]), 64'(1));
    aresetn = 1'b0;
    #1;
    check_reset("midrst");
    q1.delete();
    q2.delete();
    last1 = '0;
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, '0);
      chk("post_rst_sts", 64'(m_sts), 64'(4'b0010));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
